vliw_fwd_scoreboard: RTL and testbench
======================================

Name: vliw_fwd_scoreboard

Overview:
- Parametrised forwarding and hazard unit for the VLIW pipeline; generalises the two-slot (main + compressed) forwarding selector to SLOTS issue slots, NSRC sources per slot and DEPTH tracked stages.
- Keeps its own registered copy of in-flight destination registers per stage and slot, so execute-stage bookkeeping is not needed.
- Sits beside decode: produces per-source bypass selects, a load-use stall request and a saturating stall counter.

Parameters:
- SLOTS, 2, issue slots per bundle.
- NSRC, 2, source operands per slot.
- DEPTH, 2, tracked stages after decode; stage 1 = EX, stage DEPTH = last stage before writeback.
- REG_W, 5, register index width.
- SEL_W, $clog2(DEPTH*SLOTS+1), width of one forwarding select.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode bundle valid.
- id_src  in  SLOTS*NSRC*REG_W  source registers, slot-major; index = s*NSRC+j.
- id_src_used  in  SLOTS*NSRC  source j of slot s is actually read.
- id_dst  in  SLOTS*REG_W  destination register per slot.
- id_regwr  in  SLOTS  slot writes a register.
- id_load  in  SLOTS  slot is a load; data is available only from stage 2.
- freeze  in  1  external full-pipeline hold.
- flush  in  1  kill the bundle leaving decode (branch or jump redirect).
- fwd_sel  out  SLOTS*NSRC*SEL_W  bypass select per source.
- lu_stall  out  1  load-use stall request.
- stall_cnt  out  CNT_W  cycles stalled by load-use, saturating.

Behaviour:
- State: entry[k][s] = {valid, regwr, load, dst} for k = 1..DEPTH and s = 0..SLOTS-1.
- Reset (async, rst_n = 0): all entry fields 0; stall_cnt = 0. fwd_sel and lu_stall are combinational from state, so both read 0 during reset.

Advance rule (posedge, first matching case wins):
- freeze = 1: all entries hold; stall_cnt holds.
- flush = 1: stage 1 loads a bubble (valid = 0); stages 2..DEPTH shift.
- lu_stall = 1: same as flush (bubble into stage 1, others shift); the upstream decode stage holds its bundle.
- Otherwise: stage 1 loads {id_valid, id_regwr[s], id_load[s], id_dst[s]}; stage k+1 <= stage k.

Forwarding (combinational):
- An entry matches a source when all hold: valid, regwr, dst != 0, dst == src, and src is used.
- Stage-1 entries with load = 1 are never chosen.
- Search order is youngest stage first (k = 1 upward). Within a stage, higher slot index wins (later in bundle order).
- Select code = 1 + (k-1)*SLOTS + s; 0 means register file.
- With defaults: EX slot0 = 1, EX slot1 = 2, MEM slot0 = 3, MEM slot1 = 4.
- An unused source, or register 0, always gives 0.

Load-use stall:
- lu_stall = id_valid & !flush & (any used source, nonzero, matches a stage-1 entry with valid & regwr & load).
- lu_stall is not masked by freeze.

Stall counter:
- stall_cnt increments on a clock edge where lu_stall = 1 and freeze = 0.
- Saturates at 2^CNT_W - 1 and never wraps.

Boundaries:
- Same dst in two slots of one stage: higher slot wins.
- Same dst in EX and MEM: EX wins.
- A load in EX plus a non-load to the same register in MEM: lu_stall = 1; after one stall cycle, that source selects the load's MEM code.
- rst_n falling mid-stall clears the state and lu_stall immediately.
- No handling of intra-bundle RAW; the compiler guarantees none.

Test Plan:
- Reset: rst_n = 0 with arbitrary inputs -> fwd_sel = 0, lu_stall = 0, stall_cnt = 0. Release, then issue a bundle with no matches -> all selects 0.
- EX bypass: issue slot1 writing r7 (non-load). Next cycle, slot0 src0 = r7 used -> that select = 2. One cycle later, with bubbles issued -> select = 4. One more cycle -> 0.
- Priority: slot0 and slot1 both write r3 in one bundle, and an older bundle in MEM also wrote r3. Then a consumer of r3 -> select = 2 (youngest stage, highest slot).
- Load-use: slot0 load to r5, then a consumer of r5 -> lu_stall = 1 for one cycle and stall_cnt = 1. Next cycle (bundle held) -> lu_stall = 0 and select = 3.
- Freeze and flush:
  - Freeze during a load-use -> state and stall_cnt hold, lu_stall stays 1.
  - flush = 1 with a load in EX -> lu_stall = 0 and a bubble enters EX.
  - A src of r0, or an unused src, matching a writer of r0 -> 0.
- Saturation: with CNT_W = 4, hold a load-use for 20 cycles -> stall_cnt = 15 and it stays there.

Source files
------------

// File: rtl/vliw_fwd_scoreboard.sv
// Forwarding/hazard unit beside decode: tracks in-flight destinations per stage and slot,
// produces per-source bypass selects, a load-use stall request and a saturating stall counter.
module vliw_fwd_scoreboard #(
   parameter int SLOTS = 2,
   parameter int NSRC  = 2,
   parameter int DEPTH = 2,
   parameter int REG_W = 5,
   parameter int SEL_W = $clog2(DEPTH*SLOTS+1),
   parameter int CNT_W = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         id_valid,
   input  logic [SLOTS*NSRC*REG_W-1:0]  id_src,
   input  logic [SLOTS*NSRC-1:0]        id_src_used,
   input  logic [SLOTS*REG_W-1:0]       id_dst,
   input  logic [SLOTS-1:0]             id_regwr,
   input  logic [SLOTS-1:0]             id_load,
   input  logic                         freeze,
   input  logic                         flush,
   output logic [SLOTS*NSRC*SEL_W-1:0]  fwd_sel,
   output logic                         lu_stall,
   output logic [CNT_W-1:0]             stall_cnt
);

   // Index 0 is EX (stage 1); index DEPTH-1 is the last stage before writeback.
   logic [DEPTH-1:0][SLOTS-1:0]            ent_valid;
   logic [DEPTH-1:0][SLOTS-1:0]            ent_regwr;
   logic [DEPTH-1:0][SLOTS-1:0]            ent_load;
   logic [DEPTH-1:0][SLOTS-1:0][REG_W-1:0] ent_dst;

   logic lu_hit;

   // Scan oldest to youngest, low slot to high, so the last match (youngest, highest slot) sticks.
   function automatic logic [SEL_W-1:0] pick_sel(input logic [REG_W-1:0] src, input logic used);
      logic [SEL_W-1:0] sel;
      sel = '0;
      for (int k = DEPTH-1; k >= 0; k--) begin
         for (int s = 0; s < SLOTS; s++) begin
            if (used && (src != '0) && ent_valid[k][s] && ent_regwr[k][s] &&
                (ent_dst[k][s] == src) && !((k == 0) && ent_load[k][s]))
               sel = SEL_W'(1 + k*SLOTS + s);
         end
      end
      return sel;
   endfunction

   always_comb begin
      fwd_sel = '0;
      for (int i = 0; i < SLOTS*NSRC; i++)
         fwd_sel[i*SEL_W +: SEL_W] = pick_sel(id_src[i*REG_W +: REG_W], id_src_used[i]);
   end

   always_comb begin
      lu_hit = 1'b0;
      for (int i = 0; i < SLOTS*NSRC; i++) begin
         for (int s = 0; s < SLOTS; s++) begin
            if (id_src_used[i] && (id_src[i*REG_W +: REG_W] != '0) &&
                ent_valid[0][s] && ent_regwr[0][s] && ent_load[0][s] &&
                (ent_dst[0][s] == id_src[i*REG_W +: REG_W]))
               lu_hit = 1'b1;
         end
      end
   end

   assign lu_stall = id_valid & ~flush & lu_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent_valid <= '0;
         ent_regwr <= '0;
         ent_load  <= '0;
         ent_dst   <= '0;
         stall_cnt <= '0;
      end else if (!freeze) begin
         for (int k = 1; k < DEPTH; k++) begin
            ent_valid[k] <= ent_valid[k-1];
            ent_regwr[k] <= ent_regwr[k-1];
            ent_load[k]  <= ent_load[k-1];
            ent_dst[k]   <= ent_dst[k-1];
         end
         // A stalled or flushed bundle must not enter EX; decode re-presents it next cycle.
         if (flush || lu_stall) begin
            ent_valid[0] <= '0;
            ent_regwr[0] <= '0;
            ent_load[0]  <= '0;
            ent_dst[0]   <= '0;
         end else begin
            for (int s = 0; s < SLOTS; s++) begin
               ent_valid[0][s] <= id_valid;
               ent_regwr[0][s] <= id_regwr[s];
               ent_load[0][s]  <= id_load[s];
               ent_dst[0][s]   <= id_dst[s*REG_W +: REG_W];
            end
         end
         if (lu_stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_vliw_fwd_scoreboard.sv
// Bench for vliw_fwd_scoreboard: directed scenarios plus random traffic against a pipeline-of-bundles model.
module tb_vliw_fwd_scoreboard;
   localparam int SLOTS = 2;
   localparam int NSRC  = 2;
   localparam int DEPTH = 2;
   localparam int REG_W = 5;
   localparam int SEL_W = $clog2(DEPTH*SLOTS+1);
   localparam int CNT_W = 4;
   localparam int MAXC  = 15;
   localparam int NS    = SLOTS*NSRC;

   logic                        clk = 1'b0;
   logic                        rst_n;
   logic                        id_valid;
   logic [NS*REG_W-1:0]         id_src;
   logic [NS-1:0]               id_src_used;
   logic [SLOTS*REG_W-1:0]      id_dst;
   logic [SLOTS-1:0]            id_regwr;
   logic [SLOTS-1:0]            id_load;
   logic                        freeze;
   logic                        flush;
   logic [NS*SEL_W-1:0]         fwd_sel;
   logic                        lu_stall;
   logic [CNT_W-1:0]            stall_cnt;

   int total = 0;
   int bad   = 0;

   vliw_fwd_scoreboard #(.SLOTS(SLOTS), .NSRC(NSRC), .DEPTH(DEPTH), .REG_W(REG_W),
                         .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src),
      .id_src_used(id_src_used), .id_dst(id_dst), .id_regwr(id_regwr),
      .id_load(id_load), .freeze(freeze), .flush(flush),
      .fwd_sel(fwd_sel), .lu_stall(lu_stall), .stall_cnt(stall_cnt));

   always #5 clk = ~clk;

   // Model: the bundles that left decode, youngest at row 0.
   typedef struct {
      bit       v;
      bit       w;
      bit       l;
      bit [4:0] d;
   } bundle_ent_t;
   bundle_ent_t pipe [DEPTH][SLOTS];
   int mcnt;

   task automatic model_clear();
      for (int k = 0; k < DEPTH; k++)
         for (int s = 0; s < SLOTS; s++) begin
            pipe[k][s].v = 0; pipe[k][s].w = 0; pipe[k][s].l = 0; pipe[k][s].d = 0;
         end
      mcnt = 0;
   endtask

   function automatic logic [SEL_W-1:0] m_sel(int i);
      logic [REG_W-1:0] r;
      r = id_src[i*REG_W +: REG_W];
      if (!id_src_used[i] || r == 0) return '0;
      for (int k = 0; k < DEPTH; k++)
         for (int s = SLOTS-1; s >= 0; s--)
            if (pipe[k][s].v && pipe[k][s].w && pipe[k][s].d == r && !(k == 0 && pipe[k][s].l))
               return SEL_W'(1 + k*SLOTS + s);
      return '0;
   endfunction

   function automatic logic [NS*SEL_W-1:0] exp_fwd();
      logic [NS*SEL_W-1:0] v;
      v = '0;
      for (int i = 0; i < NS; i++) v[i*SEL_W +: SEL_W] = m_sel(i);
      return v;
   endfunction

   function automatic logic exp_lu();
      logic [REG_W-1:0] r;
      if (!id_valid || flush) return 1'b0;
      for (int i = 0; i < NS; i++) begin
         r = id_src[i*REG_W +: REG_W];
         for (int s = 0; s < SLOTS; s++)
            if (id_src_used[i] && r != 0 && pipe[0][s].v && pipe[0][s].w && pipe[0][s].l &&
                pipe[0][s].d == r)
               return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic tick();
      logic lu;
      lu = exp_lu();
      @(posedge clk);
      if (!freeze) begin
         for (int k = DEPTH-1; k >= 1; k--)
            for (int s = 0; s < SLOTS; s++) pipe[k][s] = pipe[k-1][s];
         for (int s = 0; s < SLOTS; s++) begin
            if (flush || lu) begin
               pipe[0][s].v = 0; pipe[0][s].w = 0; pipe[0][s].l = 0; pipe[0][s].d = 0;
            end else begin
               pipe[0][s].v = id_valid;
               pipe[0][s].w = id_regwr[s];
               pipe[0][s].l = id_load[s];
               pipe[0][s].d = id_dst[s*REG_W +: REG_W];
            end
         end
         if (lu && mcnt < MAXC) mcnt++;
      end
      @(negedge clk);
   endtask

   task automatic clr();
      id_valid = 1'b1; id_src = '0; id_src_used = '0; id_dst = '0;
      id_regwr = '0; id_load = '0; freeze = 1'b0; flush = 1'b0;
   endtask

   task automatic use_src(int s, int j, int r);
      id_src[(s*NSRC+j)*REG_W +: REG_W] = REG_W'(r);
      id_src_used[s*NSRC+j] = 1'b1;
   endtask

   task automatic set_wr(int s, int r, bit ld);
      id_dst[s*REG_W +: REG_W] = REG_W'(r);
      id_regwr[s] = 1'b1;
      id_load[s]  = ld;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_clear();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      clr();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_clear();
      id_valid = 1'b1; id_src = NS*REG_W'($urandom); id_src_used = '1;
      id_dst = SLOTS*REG_W'($urandom); id_regwr = '1; id_load = '1;
      freeze = 1'b0; flush = 1'b0;
      @(negedge clk); @(posedge clk); #1;
      total++; if (fwd_sel !== '0) begin bad++; $display("FAIL reset_fwd got=%h want=0", fwd_sel); end
      total++; if (lu_stall !== 1'b0) begin bad++; $display("FAIL reset_lu got=%b want=0", lu_stall); end
      total++; if (stall_cnt !== '0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", stall_cnt); end
      @(negedge clk);
      rst_n = 1'b1;
      clr();
      use_src(0, 0, 4); use_src(1, 1, 9); set_wr(0, 12, 0);
      #1;
      total++; if (fwd_sel !== '0) begin bad++; $display("FAIL nomatch_fwd got=%h want=0", fwd_sel); end
      tick();
   endtask

   task automatic test_ex_bypass();
      do_reset();
      set_wr(1, 7, 0);
      #1; tick();
      clr(); use_src(0, 0, 7);
      #1;
      total++; if (fwd_sel[0 +: SEL_W] !== SEL_W'(2)) begin bad++; $display("FAIL ex_sel got=%0d want=2", fwd_sel[0 +: SEL_W]); end
      total++; if (fwd_sel !== exp_fwd()) begin bad++; $display("FAIL ex_model got=%h want=%h", fwd_sel, exp_fwd()); end
      tick();
      id_valid = 1'b0;
      #1;
      total++; if (fwd_sel[0 +: SEL_W] !== SEL_W'(4)) begin bad++; $display("FAIL mem_sel got=%0d want=4", fwd_sel[0 +: SEL_W]); end
      tick();
      #1;
      total++; if (fwd_sel[0 +: SEL_W] !== SEL_W'(0)) begin bad++; $display("FAIL retired_sel got=%0d want=0", fwd_sel[0 +: SEL_W]); end
      tick();
   endtask

   task automatic test_priority();
      do_reset();
      set_wr(0, 3, 0);
      #1; tick();
      clr(); set_wr(0, 3, 0); set_wr(1, 3, 0);
      #1; tick();
      clr(); use_src(1, 0, 3); use_src(0, 1, 3);
      #1;
      total++; if (fwd_sel[2*SEL_W +: SEL_W] !== SEL_W'(2)) begin bad++; $display("FAIL prio_s1 got=%0d want=2", fwd_sel[2*SEL_W +: SEL_W]); end
      total++; if (fwd_sel[1*SEL_W +: SEL_W] !== SEL_W'(2)) begin bad++; $display("FAIL prio_s0 got=%0d want=2", fwd_sel[1*SEL_W +: SEL_W]); end
      tick();
   endtask

   task automatic test_load_use();
      do_reset();
      set_wr(0, 5, 1);
      #1; tick();
      clr(); use_src(0, 0, 5);
      #1;
      total++; if (lu_stall !== 1'b1) begin bad++; $display("FAIL lu_on got=%b want=1", lu_stall); end
      total++; if (fwd_sel !== '0) begin bad++; $display("FAIL lu_ex_load_skip got=%h want=0", fwd_sel); end
      tick();
      #1;
      total++; if (stall_cnt !== 4'd1) begin bad++; $display("FAIL lu_cnt got=%0d want=1", stall_cnt); end
      total++; if (lu_stall !== 1'b0) begin bad++; $display("FAIL lu_off got=%b want=0", lu_stall); end
      total++; if (fwd_sel[0 +: SEL_W] !== SEL_W'(3)) begin bad++; $display("FAIL lu_mem_sel got=%0d want=3", fwd_sel[0 +: SEL_W]); end
      tick();
      // Load in EX shadows an older non-load of the same register in MEM.
      clr(); set_wr(1, 9, 0);
      #1; tick();
      clr(); set_wr(0, 9, 1);
      #1; tick();
      clr(); use_src(1, 1, 9);
      #1;
      total++; if (lu_stall !== 1'b1) begin bad++; $display("FAIL shadow_lu got=%b want=1", lu_stall); end
      tick();
      #1;
      total++; if (fwd_sel[3*SEL_W +: SEL_W] !== SEL_W'(3)) begin bad++; $display("FAIL shadow_sel got=%0d want=3", fwd_sel[3*SEL_W +: SEL_W]); end
      tick();
      // Reset asserted mid-stall clears everything at once.
      clr(); set_wr(1, 11, 1);
      #1; tick();
      clr(); use_src(0, 1, 11);
      #1;
      total++; if (lu_stall !== 1'b1) begin bad++; $display("FAIL midrst_pre got=%b want=1", lu_stall); end
      rst_n = 1'b0;
      #1;
      total++; if (lu_stall !== 1'b0 || stall_cnt !== '0) begin bad++; $display("FAIL midrst got lu=%b cnt=%0d want 0/0", lu_stall, stall_cnt); end
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_freeze_flush();
      do_reset();
      set_wr(0, 5, 1);
      #1; tick();
      clr(); use_src(1, 1, 5); freeze = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         total++; if (lu_stall !== 1'b1 || stall_cnt !== '0) begin bad++; $display("FAIL freeze_hold got lu=%b cnt=%0d want 1/0", lu_stall, stall_cnt); end
         tick();
      end
      freeze = 1'b0;
      #1; tick();
      #1;
      total++; if (stall_cnt !== 4'd1 || fwd_sel[3*SEL_W +: SEL_W] !== SEL_W'(3)) begin bad++; $display("FAIL unfreeze got cnt=%0d sel=%0d want 1/3", stall_cnt, fwd_sel[3*SEL_W +: SEL_W]); end
      tick();
      clr(); set_wr(1, 8, 1);
      #1; tick();
      clr(); use_src(0, 0, 8); flush = 1'b1;
      #1;
      total++; if (lu_stall !== 1'b0) begin bad++; $display("FAIL flush_lu got=%b want=0", lu_stall); end
      tick();
      flush = 1'b0;
      #1;
      total++; if (lu_stall !== 1'b0 || fwd_sel[0 +: SEL_W] !== SEL_W'(4)) begin bad++; $display("FAIL flush_bubble got lu=%b sel=%0d want 0/4", lu_stall, fwd_sel[0 +: SEL_W]); end
      tick();
      clr(); set_wr(0, 0, 0); set_wr(1, 6, 0);
      #1; tick();
      clr(); use_src(0, 0, 0);
      id_src[2*REG_W +: REG_W] = 5'd6;
      #1;
      total++; if (fwd_sel !== '0) begin bad++; $display("FAIL r0_unused got=%h want=0", fwd_sel); end
      tick();
   endtask

   task automatic test_saturation();
      do_reset();
      for (int c = 0; c < 40; c++) begin
         clr(); set_wr(0, 5, 1); use_src(0, 0, 5);
         #1;
         total++; if (lu_stall !== exp_lu() || stall_cnt !== CNT_W'(mcnt)) begin bad++; $display("FAIL sat_step%0d got lu=%b cnt=%0d want %b/%0d", c, lu_stall, stall_cnt, exp_lu(), mcnt); end
         tick();
      end
      #1;
      total++; if (stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_final got=%0d want=15", stall_cnt); end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         id_valid = ($urandom_range(0, 9) < 8);
         for (int i = 0; i < NS; i++) id_src[i*REG_W +: REG_W] = REG_W'($urandom_range(0, 3));
         id_src_used = NS'($urandom);
         for (int s = 0; s < SLOTS; s++) id_dst[s*REG_W +: REG_W] = REG_W'($urandom_range(0, 3));
         id_regwr = SLOTS'($urandom);
         id_load  = SLOTS'($urandom);
         freeze = ($urandom_range(0, 9) == 0);
         flush  = ($urandom_range(0, 9) == 0);
         #1;
         total++; if (fwd_sel !== exp_fwd()) begin bad++; $display("FAIL rnd_fwd%0d got=%h want=%h", c, fwd_sel, exp_fwd()); end
         total++; if (lu_stall !== exp_lu() || stall_cnt !== CNT_W'(mcnt)) begin bad++; $display("FAIL rnd_lu%0d got lu=%b cnt=%0d want %b/%0d", c, lu_stall, stall_cnt, exp_lu(), mcnt); end
         tick();
      end
   endtask

   initial begin
      rst_n = 1'b0;
      clr();
      model_clear();
      @(negedge clk);
      test_reset();
      test_ex_bypass();
      test_priority();
      test_load_use();
      test_freeze_flush();
      test_saturation();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
